// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: sequences the alarm tone enable through a beep cadence.
// On an alarm-time match the tone is gated on/off until the user stops it,
// snoozes it (a bounded number of times per alarm event) or the ring period
// expires. All outputs are registered decodes of the next state, so a
// triggering event in cycle N is visible on the outputs in cycle N+1.
//
// Handshake note: this block has no valid/ready interfaces. alarm_match,
// snooze_p and stop_p are single-cycle pulses, each sampled on the rising
// clock edge that ends the cycle in which it is high; there is no
// backpressure, and a pulse that arrives in a state that does not use it is
// dropped.
module alarm_ring_ctrl #(
    parameter int TICK_DIV   = 100000,
    parameter int BEEP_ON_T  = 250,
    parameter int BEEP_OFF_T = 250,
    parameter int RING_T     = 60000,
    parameter int SNOOZE_T   = 300000,
    parameter int MAX_SNOOZE = 3,
    localparam int SW        = $clog2(MAX_SNOOZE + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alarm_en,
    input  logic          alarm_match,
    input  logic          snooze_p,
    input  logic          stop_p,
    output logic          tone_en,
    output logic          ringing,
    output logic          snoozing,
    output logic [SW-1:0] snooze_left,
    output logic [1:0]    state_dbg
);

    // State encoding
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RING_ON  = 2'd1;
    localparam logic [1:0] S_RING_OFF = 2'd2;
    localparam logic [1:0] S_SNOOZE   = 2'd3;

    // Counter widths: each holds its largest terminal value (parameter-1).
    localparam int PH_MAX01 = (BEEP_ON_T > BEEP_OFF_T) ? BEEP_ON_T : BEEP_OFF_T;
    localparam int PH_MAX   = (PH_MAX01 > SNOOZE_T) ? PH_MAX01 : SNOOZE_T;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PH_W     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int RING_W   = (RING_T > 1) ? $clog2(RING_T) : 1;

    // Terminal values for the terminal-compare counters
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [PH_W-1:0]   ON_LAST   = PH_W'(BEEP_ON_T - 1);
    localparam logic [PH_W-1:0]   OFF_LAST  = PH_W'(BEEP_OFF_T - 1);
    localparam logic [PH_W-1:0]   SNZ_LAST  = PH_W'(SNOOZE_T - 1);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_T - 1);
    localparam logic [SW-1:0]     SNZ_FULL  = SW'(MAX_SNOOZE);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [PRE_W-1:0]  presc_q;
    logic [PH_W-1:0]   phase_q;
    logic [RING_W-1:0] ring_q;
    logic [SW-1:0]     snooze_left_q;

    logic tick;
    logic in_ring;
    logic state_change;
    logic snooze_take;
    logic ring_clr;

    assign tick         = (presc_q == PRE_LAST);
    assign in_ring      = (state_q == S_RING_ON) || (state_q == S_RING_OFF);
    assign state_change = (state_d != state_q);

    // ring_cnt restarts whenever a fresh ringing period begins: from IDLE
    // (new alarm) or from SNOOZE (resume). RING_OFF -> RING_ON keeps counting.
    assign ring_clr = (state_d == S_RING_ON) &&
                      ((state_q == S_IDLE) || (state_q == S_SNOOZE));

    // Next-state selection; the if/else order is the transition priority.
    always_comb begin
        state_d     = state_q;
        snooze_take = 1'b0;
        if (!alarm_en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (alarm_match) begin
                        state_d = S_RING_ON;
                    end
                end
                S_RING_ON, S_RING_OFF: begin
                    if (stop_p) begin
                        state_d = S_IDLE;
                    end else if (snooze_p && (snooze_left_q != '0)) begin
                        state_d     = S_SNOOZE;
                        snooze_take = 1'b1;
                    end else if (tick && (ring_q == RING_LAST)) begin
                        // Timeout wins over a coincident beep phase change.
                        state_d = S_IDLE;
                    end else if (tick && (state_q == S_RING_ON) && (phase_q == ON_LAST)) begin
                        state_d = S_RING_OFF;
                    end else if (tick && (state_q == S_RING_OFF) && (phase_q == OFF_LAST)) begin
                        state_d = S_RING_ON;
                    end
                end
                S_SNOOZE: begin
                    if (stop_p) begin
                        state_d = S_IDLE;
                    end else if (tick && (phase_q == SNZ_LAST)) begin
                        state_d = S_RING_ON;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Timebase prescaler: restarts on every state change so each phase lasts
    // an exact multiple of TICK_DIV cycles; held at zero while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (state_change || (state_q == S_IDLE)) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRE_W'(1);
        end
    end

    // Phase counter: ticks spent in the current beep-on, beep-off or snooze phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else if (state_change) begin
            phase_q <= '0;
        end else if (tick && (state_q != S_IDLE)) begin
            phase_q <= phase_q + PH_W'(1);
        end
    end

    // Ring counter: ticks since the ring started or resumed after a snooze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring_q <= '0;
        end else if (ring_clr) begin
            ring_q <= '0;
        end else if (tick && in_ring && (state_d != S_IDLE)) begin
            ring_q <= ring_q + RING_W'(1);
        end
    end

    // Snooze budget: consumed by each accepted snooze, refilled on return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snooze_left_q <= SNZ_FULL;
        end else if (state_d == S_IDLE) begin
            snooze_left_q <= SNZ_FULL;
        end else if (snooze_take) begin
            snooze_left_q <= snooze_left_q - SW'(1);
        end
    end

    // Registered output decode of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_en  <= 1'b0;
            ringing  <= 1'b0;
            snoozing <= 1'b0;
        end else begin
            tone_en  <= (state_d == S_RING_ON);
            ringing  <= (state_d == S_RING_ON) || (state_d == S_RING_OFF);
            snoozing <= (state_d == S_SNOOZE);
        end
    end

    assign snooze_left = snooze_left_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb_alarm_ring_ctrl: directed scenarios for alarm_ring_ctrl with a
// cycle-tagged expected queue and an independent output monitor.
module tb_alarm_ring_ctrl;

    localparam int TICK_DIV   = 4;
    localparam int BEEP_ON_T  = 3;
    localparam int BEEP_OFF_T = 2;
    localparam int RING_T     = 20;
    localparam int SNOOZE_T   = 10;
    localparam int MAX_SNOOZE = 2;
    localparam int SW         = $clog2(MAX_SNOOZE + 1);
    localparam int W          = 3 + SW;

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b0;
    logic          alarm_en    = 1'b1;
    logic          alarm_match = 1'b0;
    logic          snooze_p    = 1'b0;
    logic          stop_p      = 1'b0;
    logic          tone_en;
    logic          ringing;
    logic          snoozing;
    logic [SW-1:0] snooze_left;
    logic [1:0]    state_dbg;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // Expected output vector {tone_en, ringing, snoozing, snooze_left}
    // tagged with the cycle in which it must be observed.
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];

    int           mon_c;
    logic [W-1:0] mon_v;
    logic [W-1:0] mon_act;
    int           n, m, s, r, c;

    alarm_ring_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .BEEP_ON_T  (BEEP_ON_T),
        .BEEP_OFF_T (BEEP_OFF_T),
        .RING_T     (RING_T),
        .SNOOZE_T   (SNOOZE_T),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alarm_en    (alarm_en),
        .alarm_match (alarm_match),
        .snooze_p    (snooze_p),
        .stop_p      (stop_p),
        .tone_en     (tone_en),
        .ringing     (ringing),
        .snoozing    (snoozing),
        .snooze_left (snooze_left),
        .state_dbg   (state_dbg)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic expect_seg(input int start, input int len, input logic t,
                              input logic rg, input logic sn, input logic [SW-1:0] left);
        for (int i = 0; i < len; i++) begin
            exp_cyc_q.push_back(start + i);
            exp_q.push_back({t, rg, sn, left});
        end
    endtask

    task automatic wait_until(input int cy);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < cy);
    endtask

    task automatic pulse_at(input int cy, input logic pm, input logic ps, input logic pt);
        wait_until(cy);
        alarm_match = pm;
        snooze_p    = ps;
        stop_p      = pt;
        @(posedge clk);
        #1;
        alarm_match = 1'b0;
        snooze_p    = 1'b0;
        stop_p      = 1'b0;
    endtask

    task automatic expect_cadence(input int base, input int beeps, input logic [SW-1:0] left);
        for (int b = 0; b < beeps; b++) begin
            expect_seg(base + 20 * b,      12, 1'b1, 1'b1, 1'b0, left);
            expect_seg(base + 20 * b + 12,  8, 1'b0, 1'b1, 1'b0, left);
        end
    endtask

    // Scoreboard monitor: compares every expectation due in the current cycle.
    always @(negedge clk) begin
        while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
            mon_c   = exp_cyc_q.pop_front();
            mon_v   = exp_q.pop_front();
            mon_act = {tone_en, ringing, snoozing, snooze_left};
            checks++;
            if (mon_c < cyc) begin
                errors++;
                $display("FAIL late_expect cycle %0d seen at %0d: got %b want %b",
                         mon_c, cyc, mon_act, mon_v);
            end else if (mon_act !== mon_v) begin
                errors++;
                $display("FAIL outputs cycle %0d: got {tone,ring,snz,left}=%b want %b",
                         mon_c, mon_act, mon_v);
            end
        end
    end

    // Stimulus
    initial begin
        // Reset state while rst_n is held low
        repeat (3) @(posedge clk);
        #1;
        expect_seg(cyc, 1, 1'b0, 1'b0, 1'b0, 2'd2);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = cyc;
        expect_seg(n, 4, 1'b0, 1'b0, 1'b0, 2'd2);
        wait_until(n + 3);

        // Full ring: 4 beeps of 12 on / 8 off, then timeout to IDLE
        m = n + 5;
        pulse_at(m, 1'b1, 1'b0, 1'b0);
        expect_cadence(m + 1, 4, 2'd2);
        expect_seg(m + 81, 5, 1'b0, 1'b0, 1'b0, 2'd2);
        wait_until(m + 86);

        // Snooze mid-beep, resume after 40 cycles with a fresh ring timeout
        m = cyc + 2;
        pulse_at(m, 1'b1, 1'b0, 1'b0);
        expect_seg(m + 1, 6, 1'b1, 1'b1, 1'b0, 2'd2);
        s = m + 6;
        pulse_at(s, 1'b0, 1'b1, 1'b0);
        expect_seg(s + 1, 40, 1'b0, 1'b0, 1'b1, 2'd1);
        r = s + 41;
        expect_cadence(r, 4, 2'd1);
        expect_seg(r + 80, 3, 1'b0, 1'b0, 1'b0, 2'd2);
        wait_until(r + 83);

        // Exhaust snoozes, third is ignored, stop returns to IDLE with budget refilled
        m = cyc + 2;
        pulse_at(m, 1'b1, 1'b0, 1'b0);
        expect_seg(m + 1, 2, 1'b1, 1'b1, 1'b0, 2'd2);
        pulse_at(m + 2, 1'b0, 1'b1, 1'b0);
        expect_seg(m + 3, 40, 1'b0, 1'b0, 1'b1, 2'd1);
        expect_seg(m + 43, 2, 1'b1, 1'b1, 1'b0, 2'd1);
        pulse_at(m + 44, 1'b0, 1'b1, 1'b0);
        expect_seg(m + 45, 40, 1'b0, 1'b0, 1'b1, 2'd0);
        r = m + 85;
        expect_seg(r,      12, 1'b1, 1'b1, 1'b0, 2'd0);
        expect_seg(r + 12,  8, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_seg(r + 20,  6, 1'b1, 1'b1, 1'b0, 2'd0);
        pulse_at(r + 3, 1'b0, 1'b1, 1'b0);
        pulse_at(r + 25, 1'b0, 1'b0, 1'b1);
        expect_seg(r + 26, 3, 1'b0, 1'b0, 1'b0, 2'd2);
        wait_until(r + 29);

        // Stop and snooze in the same cycle: stop wins
        m = cyc + 2;
        pulse_at(m, 1'b1, 1'b0, 1'b0);
        expect_seg(m + 1, 3, 1'b1, 1'b1, 1'b0, 2'd2);
        pulse_at(m + 3, 1'b0, 1'b1, 1'b1);
        expect_seg(m + 4, 3, 1'b0, 1'b0, 1'b0, 2'd2);
        wait_until(m + 7);

        // alarm_en dropped mid-snooze, then a match while disabled is ignored
        m = cyc + 2;
        pulse_at(m, 1'b1, 1'b0, 1'b0);
        expect_seg(m + 1, 2, 1'b1, 1'b1, 1'b0, 2'd2);
        pulse_at(m + 2, 1'b0, 1'b1, 1'b0);
        expect_seg(m + 3, 10, 1'b0, 1'b0, 1'b1, 2'd1);
        wait_until(m + 12);
        alarm_en = 1'b0;
        expect_seg(m + 13, 2, 1'b0, 1'b0, 1'b0, 2'd2);
        c = m + 14;
        pulse_at(c, 1'b1, 1'b0, 1'b0);
        expect_seg(c + 1, 4, 1'b0, 1'b0, 1'b0, 2'd2);
        wait_until(c + 5);
        alarm_en = 1'b1;

        // Asynchronous reset between edges mid-beep
        m = cyc + 2;
        pulse_at(m, 1'b1, 1'b0, 1'b0);
        expect_seg(m + 1, 4, 1'b1, 1'b1, 1'b0, 2'd2);
        wait_until(m + 5);
        expect_seg(m + 5, 4, 1'b0, 1'b0, 1'b0, 2'd2);
        #2;
        rst_n = 1'b0;
        wait_until(m + 8);
        rst_n = 1'b1;
        expect_seg(m + 9, 10, 1'b0, 1'b0, 1'b0, 2'd2);
        wait_until(m + 19);

        // A new match after reset rings normally again
        pulse_at(m + 20, 1'b1, 1'b0, 1'b0);
        expect_seg(m + 21, 12, 1'b1, 1'b1, 1'b0, 2'd2);
        expect_seg(m + 33,  2, 1'b0, 1'b1, 1'b0, 2'd2);
        wait_until(m + 36);

        // Final report
        repeat (2) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors += exp_q.size();
            $display("FAIL unchecked_expectations: got %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
